frame_tx_scheduler: RTL
=======================

Name: frame_tx_scheduler

Overview:
Round-robin scheduler that shares the 16-bit framed input stream of frame_detector among NREQ requesters. It arbitrates one request at a time and sequences a complete frame onto data_out, driven by an 8-state FSM:
- header E0E0/E0E0
- channel word
- payload
- CRC-16
- trailer 0E0E/0E0E

It sits in front of frame_detector on the clk_in domain and holds off new frames while the detector FIFO reports full.

Parameters:
NREQ, 4, number of requesters (2..8)
MAX_WORDS, 8, maximum payload words per frame (128 bits)

Ports:
clk_in  in  1  input-domain clock
rst  in  1  synchronous reset, active-high
fifo_full  in  1  frame_detector FIFO full; blocks frame start only
req  in  NREQ  per-requester frame request, level
req_ch  in  8*NREQ  per-requester target channel, one-hot, slice i = [8i+7:8i]
req_len  in  4*NREQ  per-requester payload length in words (1..MAX_WORDS)
pld_data  in  16*NREQ  per-requester current payload word
grant  out  NREQ  one-hot owner of current frame, 0 when idle
pld_rd  out  1  pulse: granted requester's pld_data consumed this cycle, advance to next word
data_out  out  16  framed stream to frame_detector.data_in
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse on last trailer word
cfg_err  out  1  one-cycle pulse: a request was rejected
cfg_err_idx  out  3  index of rejected requester, valid with cfg_err

Behaviour:
Reset values:
- Synchronous rst, active-high.
- All outputs 0, data_out=16'h0000.
- RR pointer=0, FSM=IDLE.
- rst mid-frame aborts immediately; the next cycle outputs idle 0000 and there is no trailer.

FSM states: IDLE, HDR_HI, HDR_LO, CHAN, PLD, CRC, TRL_HI, TRL_LO.

IDLE:
- Holds data_out=0000.
- If fifo_full=0 and any req set, selects the first set req at or after the RR pointer (wrapping).
- Checks the selected request:
  - req_ch not exactly one-hot, or req_len=0 or >MAX_WORDS: reject it with cfg_err=1 and cfg_err_idx=index on the next cycle. Advance the RR pointer past it and stay IDLE.
  - Otherwise, latch ch, len and index, set grant/busy, and go to HDR_HI.
- If fifo_full=1, no arbitration takes place; requests wait.

Per-state data_out and transitions (data_out is registered; each state's word is visible the cycle after entry):
- HDR_HI: E0E0, then HDR_LO.
- HDR_LO: E0E0, then CHAN.
- CHAN: {8'h00, ch}; CRC register loaded to 16'hFFFF.
- PLD: len cycles, data_out=pld_data[granted].
  - pld_rd=1 each PLD cycle.
  - Each word is folded into the CRC.
  - The word counter counts 0..len-1, then goes to CRC.
- CRC: final CRC value, then TRL_HI.
- TRL_HI: 0E0E, then TRL_LO.
- TRL_LO: 0E0E with frame_done=1.
  - The RR pointer moves to grant index+1 mod NREQ.
  - grant and busy clear, FSM returns to IDLE.

Timing:
- Frame length on data_out = 6+len cycles.
- Minimum inter-frame gap is 1 idle (0000) cycle.
- Latency from arbitration edge to first E0E0 is 1 cycle.

CRC:
- CRC-16/CCITT-FALSE: poly 0x1021, init 0xFFFF, MSB-first, no reflection, xorout 0.
- Computed over payload words only, one 16-bit word per cycle (combinational 16-step update).

Simultaneous events and stalls:
- req deassert or req_ch/req_len change after grant: ignored; the latched values are used and the frame completes.
- fifo_full rising mid-frame: ignored; the frame is not stalled.
- Simultaneous requests: served strictly round-robin.
- A requester holding req continuously gets at most one frame per round.

Optional Feature:
Macro FRAME_TX_CRC_INJ_EN.
- Defined: adds input port crc_inj (1 bit), sampled at arbitration. When 1, the CRC word for that frame is sent bit-inverted so the detector asserts crc_err. Payload and trailer are unaffected.
- Undefined: port absent; CRC is always correct.

Test Plan:
1. Reset, then req[0]=1, ch=8'h01, len=1, pld_data=0000 -> data_out sequence E0E0,E0E0,0001,0000,1D0F,0E0E,0E0E. pld_rd high exactly 1 cycle, frame_done on the last word, grant=0001 during the frame.
2. req[1], ch=8'h02, len=8, payload 0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> 14-cycle frame, 8 pld_rd pulses, CRC equals the golden-model value. The full frame must pass through frame_detector with crc_valid=1 and CH2 output matching gray(payload).
3. req=4'b1111 held, all valid, len=1 -> grant order 0,1,2,3,0; each frame separated by exactly 1 idle 0000 cycle.
4. req[2] with ch=8'h03 and req[3] with len=0 -> cfg_err pulses with idx=2 then idx=3, no frame emitted, data_out stays 0000.
5. fifo_full=1 with req[0] pending -> no header for 20 cycles. Release fifo_full -> header appears 1 cycle after the arbitration edge. Assert fifo_full mid-payload -> frame still completes.
6. Assert rst during PLD of a len=8 frame -> next cycle data_out=0000, grant=0, busy=0. Subsequent req[1] is served first with RR pointer 0 and a correct full frame. With FRAME_TX_CRC_INJ_EN and crc_inj=1 in scenario 1, the CRC word is E2F0.

Source files
------------

// File: rtl/frame_tx_scheduler.sv
// Round-robin frame scheduler feeding frame_detector: header, channel, payload, CRC-16, trailer.
// Optional macro FRAME_TX_CRC_INJ_EN adds crc_inj to send a deliberately inverted CRC word.
module frame_tx_scheduler #(
    parameter int NREQ      = 4,
    parameter int MAX_WORDS = 8
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 fifo_full,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    req_ch,
    input  logic [4*NREQ-1:0]    req_len,
    input  logic [16*NREQ-1:0]   pld_data,
`ifdef FRAME_TX_CRC_INJ_EN
    input  logic                 crc_inj,
`endif
    output logic [NREQ-1:0]      grant,
    output logic                 pld_rd,
    output logic [15:0]          data_out,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 cfg_err,
    output logic [2:0]           cfg_err_idx
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [4:0] MAXW = 5'(MAX_WORDS);

    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, CHAN, PLD, CRC, TRL_HI, TRL_LO} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d, gidx_q, gidx_d;
    logic [7:0]        ch_q, ch_d;
    logic [3:0]        len_q, len_d, cnt_q, cnt_d;
    logic [15:0]       crc_q, crc_d, data_q, data_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [2:0]        err_idx_q, err_idx_d;
    logic              inj_q, inj_d;

    logic              sel_found, sel_ok;
    logic [IW-1:0]     sel_idx;
    logic [7:0]        sel_ch;
    logic [3:0]        sel_len;
    logic [15:0]       cur_pld;

    // CRC-16/CCITT-FALSE, one 16-bit word folded MSB-first
    function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int b = 15; b >= 0; b--) begin
            if (c[15] ^ d[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] i);
        return (i == IW'(NREQ-1)) ? '0 : i + 1'b1;
    endfunction

    // First pending requester at or after the round-robin pointer
    always_comb begin
        int j;
        j         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_ch    = '0;
        sel_len   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_q) + k) % NREQ;
            if (!sel_found && req[j]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(j);
                sel_ch    = req_ch[8*j +: 8];
                sel_len   = req_len[4*j +: 4];
            end
        end
        sel_ok = $onehot(sel_ch) && (sel_len != 4'd0) && ({1'b0, sel_len} <= MAXW);
    end

    assign cur_pld = pld_data[16*int'(gidx_q) +: 16];

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gidx_d    = gidx_q;
        ch_d      = ch_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        inj_d     = inj_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        data_d    = 16'h0000;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_idx_d = 3'd0;
        case (state_q)
            IDLE: begin
                if (!fifo_full && sel_found) begin
                    rr_d = nxt_idx(sel_idx);
                    if (!sel_ok) begin
                        err_d     = 1'b1;
                        err_idx_d = 3'(sel_idx);
                    end else begin
                        rr_d    = rr_q;
                        ch_d    = sel_ch;
                        len_d   = sel_len;
                        gidx_d  = sel_idx;
                        grant_d = NREQ'(1) << sel_idx;
                        busy_d  = 1'b1;
`ifdef FRAME_TX_CRC_INJ_EN
                        inj_d   = crc_inj;
`else
                        inj_d   = 1'b0;
`endif
                        state_d = HDR_HI;
                    end
                end
            end
            HDR_HI: begin data_d = 16'hE0E0; state_d = HDR_LO; end
            HDR_LO: begin data_d = 16'hE0E0; state_d = CHAN; end
            CHAN: begin
                data_d  = {8'h00, ch_q};
                crc_d   = 16'hFFFF;
                cnt_d   = 4'd0;
                state_d = PLD;
            end
            PLD: begin
                data_d = cur_pld;
                crc_d  = crc16_word(crc_q, cur_pld);
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == len_q - 4'd1) state_d = CRC;
            end
            CRC: begin
                data_d  = inj_q ? ~crc_q : crc_q;
                state_d = TRL_HI;
            end
            TRL_HI: begin data_d = 16'h0E0E; state_d = TRL_LO; end
            TRL_LO: begin
                data_d  = 16'h0E0E;
                done_d  = 1'b1;
                rr_d    = nxt_idx(gidx_q);
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            data_q    <= 16'h0000;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    // Frame context is only meaningful while busy, so it carries no reset
    always_ff @(posedge clk_in) begin
        gidx_q <= gidx_d;
        ch_q   <= ch_d;
        len_q  <= len_d;
        cnt_q  <= cnt_d;
        crc_q  <= crc_d;
        inj_q  <= inj_d;
    end

    assign grant       = grant_q;
    assign pld_rd      = (state_q == PLD);
    assign data_out    = data_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign cfg_err     = err_q;
    assign cfg_err_idx = err_idx_q;
endmodule
